// File: rtl/sram_like_responder.sv
// sram_like_responder: target end of the SRAM-like req/addr_ok/data_ok interface.
// Accepts pipelined requests, drives a 1-cycle-latency synchronous SRAM and returns
// exactly one in-order data_ok per accepted request, with a minimum latency of two cycles.
// Optional build macro SRAM_LIKE_RAND_STALL_EN: a 16-bit LFSR randomly withholds addr_ok
// and data_ok to stress the master; ordering and response counts are unaffected.
module sram_like_responder #(
  parameter int unsigned DEPTH = 4  // max outstanding requests; power of 2, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata,
  output logic        o_ram_en,
  output logic [3:0]  o_ram_wen,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  input  logic [31:0] i_ram_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  // Outstanding count covers the pending slot plus every FIFO entry, so it also bounds
  // FIFO occupancy and the FIFO can never overflow.
  logic [PTR_W:0]  r_out_cnt;
  logic [PTR_W:0]  r_wptr;
  logic [PTR_W:0]  r_rptr;
  logic            r_pend_vld;
  logic            r_pend_wr;
  logic [31:0]     r_mem [DEPTH];

  logic            w_acc_gate;
  logic            w_pop_gate;
  logic            w_addr_ok;
  logic            w_accept;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_push_data;

  // Transfer size is informational only; byte lanes come from wstrb.
  logic            w_unused_size;
  assign w_unused_size = ^i_size;

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running source of random stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_acc_gate = r_lfsr[0];
  assign w_pop_gate = r_lfsr[1];
`else
  assign w_acc_gate = 1'b1;
  assign w_pop_gate = 1'b1;
`endif

  // Handshake decode: addr_ok looks at registered state only, never at req.
  always_comb begin
    w_addr_ok    = !reset && (r_out_cnt < DEPTH_CNT) && w_acc_gate;
    w_accept     = i_req && w_addr_ok;
    w_fifo_empty = (r_wptr == r_rptr);
    w_pop        = !reset && !w_fifo_empty && w_pop_gate;
    w_push       = !reset && r_pend_vld;
    w_push_data  = r_pend_wr ? 32'h0 : i_ram_rdata;
  end

  // Outputs: backend is driven straight from the accepted request in the same cycle.
  always_comb begin
    o_addr_ok   = w_addr_ok;
    o_data_ok   = w_pop;
    o_rdata     = w_pop ? r_mem[r_rptr[PTR_W-1:0]] : 32'h0;
    o_ram_en    = w_accept;
    o_ram_wen   = (w_accept && i_wr) ? i_wstrb : 4'h0;
    o_ram_addr  = i_addr;
    o_ram_wdata = i_wdata;
  end

  // Control state: outstanding count, pending slot and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_cnt  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_wr  <= 1'b0;
    end else begin
      unique case ({w_accept, w_pop})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
      r_pend_vld <= w_accept;
      r_pend_wr  <= i_wr;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Response storage: SRAM read data is captured the cycle after the request.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_push_data;
    end
  end

endmodule
